dense_out_serializer: RTL and testbench
=======================================

Name: dense_out_serializer

Overview:
- Sits directly downstream of dense_layer.
- Captures the flattened OUT_FEATURES x DATA_W result vector on a single-cycle in_valid pulse.
- Streams the vector out as BEAT_FEATURES-wide beats over a valid/ready interface toward the next layer or host.
- Upstream has no backpressure, so vectors arriving while the block is busy are dropped and counted, never corrupting the stream in flight.

Parameters:
OUT_FEATURES, 64, number of features in the input vector
DATA_W, 8, bits per feature
BEAT_FEATURES, 4, features per output beat; OUT_FEATURES must be a multiple (NUM_BEATS = OUT_FEATURES/BEAT_FEATURES = 16)

Ports:
clk  input  1  clock; all logic on the rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  OUT_FEATURES*DATA_W  flattened vector; feature i at bits [i*DATA_W +: DATA_W]
in_valid  input  1  vector-present pulse (dense_layer data_out_valid)
in_ready  output  1  block can accept a vector this cycle (informational; upstream ignores it)
m_data  output  BEAT_FEATURES*DATA_W  current beat; beat k holds features k*BEAT_FEATURES.., lowest feature in the LSBs
m_valid  output  1  beat valid
m_ready  input  1  downstream accepts beat
m_last  output  1  high with the final beat (index NUM_BEATS-1)
drop_cnt  output  16  count of vectors dropped while busy, saturating at 0xFFFF

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE; m_valid=0, m_last=0, m_data=0, drop_cnt=0, beat counter=0, buffer cleared.
  - in_ready=1 after reset is released.
- States: IDLE, STREAM.
- IDLE:
  - in_ready=1, m_valid=0.
  - in_valid=1 at edge N captures in_data into the buffer, sets beat=0, goes to STREAM.
  - m_valid=1 from cycle N+1 (one-cycle latency).
- STREAM:
  - m_valid=1; m_data = buffer slice for beat; m_last = (beat==NUM_BEATS-1).
  - Handshake completes on m_valid & m_ready at a rising edge.
  - Non-last beat accepted: beat increments.
  - m_valid=0 is never asserted mid-vector; m_data/m_last hold stable while m_ready=0.
  - Last beat accepted with in_valid=0: go to IDLE.
  - Last beat accepted with in_valid=1 in the same cycle: capture the new vector, beat=0, stay in STREAM. m_valid stays high (no bubble).
- in_ready (combinational) = IDLE | (STREAM & beat==NUM_BEATS-1 & m_ready).
- Drop rule:
  - in_valid=1 while in_ready=0: vector discarded; buffer, beat and stream unaffected.
  - drop_cnt increments by 1, saturating at 0xFFFF (no wrap).
- Counter wrap: beat runs 0..NUM_BEATS-1 only; it never exceeds the final index.
- Reset mid-stream: the stream aborts immediately. No m_last is emitted and the partial vector is lost. Outputs return to reset values asynchronously.
- Widths: features are passed bit-exact (except under RELU_EN). No arithmetic beyond counters.

Optional Feature:
- Macro: DENSE_OUT_RELU_EN.
- Defined: at capture, each feature is treated as two's-complement DATA_W-bit. Negative features (MSB=1) are stored as 0; non-negative features are unchanged. The clamp is applied in the capture path, so latency is unchanged.
- Undefined: features are stored and emitted bit-exact, no interpretation of sign.

Test Plan:
1. Reset then in_valid pulse with feature i = i%256 and m_ready held 1 -> m_valid rises next cycle.
   - 16 consecutive beats; beat0 m_data=0x03020100, beat15 m_data=0x3F3E3D3C with m_last=1.
   - Then IDLE, drop_cnt=0.
2. Same vector, m_ready toggling 1/0 each cycle -> identical 16-beat sequence. m_data/m_last stable across every stalled cycle; no beat skipped or repeated.
3. in_valid pulse during beat 5 with feature i = 0xAA -> drop_cnt=1; remaining beats still carry the first vector's values (beat6=0x1B1A1918).
4. Second vector (feature i = (1+i*3)%256) presented in the same cycle the last beat is accepted -> in_ready=1 that cycle, m_valid never drops.
   - Next beat m_data=0x0A070401; drop_cnt=0.
5. rst_n pulsed low during beat 8 -> m_valid, m_last, m_data go 0 immediately; drop_cnt=0.
   - After release, a fresh vector streams from beat 0.
6. All features 0xFF, then all 0x7F:
   - Without the macro: beats 0xFFFFFFFF and 0x7F7F7F7F.
   - With DENSE_OUT_RELU_EN: beats 0x00000000 and 0x7F7F7F7F.

Source files
------------

// File: rtl/dense_out_serializer_if.sv
// Stream bundle for dense_out_serializer: wide vector capture side plus
// the beat-wise valid/ready output side and the drop counter.
interface dense_out_serializer_if #(
   parameter int OUT_FEATURES  = 64,
   parameter int DATA_W        = 8,
   parameter int BEAT_FEATURES = 4
);
   logic [OUT_FEATURES*DATA_W-1:0]  in_data;
   logic                            in_valid;
   logic                            in_ready;
   logic [BEAT_FEATURES*DATA_W-1:0] m_data;
   logic                            m_valid;
   logic                            m_ready;
   logic                            m_last;
   logic [15:0]                     drop_cnt;

   // master = environment (upstream layer + downstream sink), slave = serializer
   modport master (
      output in_data, in_valid, m_ready,
      input  in_ready, m_data, m_valid, m_last, drop_cnt
   );

   modport slave (
      input  in_data, in_valid, m_ready,
      output in_ready, m_data, m_valid, m_last, drop_cnt
   );
endinterface

// File: rtl/dense_out_serializer.sv
// Captures a dense_layer result vector and streams it as fixed-width beats.
// Optional macro DENSE_OUT_RELU_EN clamps negative features to zero at capture.
module dense_out_serializer #(
   parameter int OUT_FEATURES  = 64,
   parameter int DATA_W        = 8,
   parameter int BEAT_FEATURES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   dense_out_serializer_if.slave  bus
);
   localparam int VEC_W      = OUT_FEATURES * DATA_W;
   localparam int BEAT_W     = BEAT_FEATURES * DATA_W;
   localparam int NUM_BEATS  = OUT_FEATURES / BEAT_FEATURES;
   localparam int BEAT_CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(NUM_BEATS - 1);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_STREAM = 1'b1;

   if ((OUT_FEATURES % BEAT_FEATURES) != 0) begin : g_bad_cfg
      $error("OUT_FEATURES must be a multiple of BEAT_FEATURES");
   end

   logic [0:0]            state_q,    state_d;
   logic [BEAT_CNT_W-1:0] beat_q,     beat_d;
   logic [VEC_W-1:0]      vec_q,      vec_d;
   logic [15:0]           drop_cnt_q, drop_cnt_d;

   logic [VEC_W-1:0]      cap_data;
   logic [BEAT_W-1:0]     beat_words [NUM_BEATS];
   logic                  streaming;
   logic                  on_last;
   logic                  beat_taken;
   logic                  in_ready_c;
   logic                  capture;
   logic                  drop;

   genvar gi;

   // Capture path; the optional clamp is pure combinational so latency is unchanged
   generate
      for (gi = 0; gi < OUT_FEATURES; gi++) begin : g_cap
`ifdef DENSE_OUT_RELU_EN
         assign cap_data[gi*DATA_W +: DATA_W] =
            bus.in_data[gi*DATA_W + DATA_W - 1] ? '0 : bus.in_data[gi*DATA_W +: DATA_W];
`else
         assign cap_data[gi*DATA_W +: DATA_W] = bus.in_data[gi*DATA_W +: DATA_W];
`endif
      end

      for (gi = 0; gi < NUM_BEATS; gi++) begin : g_beat
         assign beat_words[gi] = vec_q[gi*BEAT_W +: BEAT_W];
      end
   endgenerate

   assign streaming  = (state_q == ST_STREAM);
   assign on_last    = streaming && (beat_q == LAST_BEAT);
   assign beat_taken = streaming && bus.m_ready;
   // A new vector may land in the same cycle the final beat leaves, so no bubble
   assign in_ready_c = !streaming || (on_last && bus.m_ready);
   assign capture    = bus.in_valid && in_ready_c;
   assign drop       = bus.in_valid && !in_ready_c;

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      vec_d      = vec_q;
      drop_cnt_d = drop_cnt_q;

      if (!streaming) begin
         if (capture) begin
            state_d = ST_STREAM;
            beat_d  = '0;
            vec_d   = cap_data;
         end
      end else if (beat_taken) begin
         if (on_last) begin
            beat_d = '0;
            if (capture) begin
               vec_d = cap_data;
            end else begin
               state_d = ST_IDLE;
            end
         end else begin
            beat_d = beat_q + BEAT_CNT_W'(1);
         end
      end

      if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         beat_q     <= '0;
         vec_q      <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         vec_q      <= vec_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Outputs derive only from flops (and m_ready for in_ready), so reset clears them at once
   assign bus.in_ready = in_ready_c;
   assign bus.m_valid  = streaming;
   assign bus.m_last   = on_last;
   assign bus.m_data   = streaming ? beat_words[beat_q] : '0;
   assign bus.drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_dense_out_serializer.sv
// Self-checking bench for dense_out_serializer: directed scenarios plus a
// randomized run, all compared against a queue-of-beats reference model.
module tb_dense_out_serializer;
   localparam int OF = 64;
   localparam int DW = 8;
   localparam int BF = 4;
   localparam int NB = OF / BF;
   localparam int VW = OF * DW;
   localparam int BW = BF * DW;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dense_out_serializer_if #(.OUT_FEATURES(OF), .DATA_W(DW), .BEAT_FEATURES(BF)) ifc ();

   dense_out_serializer #(.OUT_FEATURES(OF), .DATA_W(DW), .BEAT_FEATURES(BF)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: beats still owed downstream, oldest first, plus the drop tally
   logic [BW-1:0] exp_q[$];
   int            exp_drops = 0;

   logic [VW-1:0] vec_a, vec_b, vec_aa, vec_ff, vec_7f, vec_r;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [VW-1:0] stored(input logic [VW-1:0] v);
      logic [VW-1:0] r;
      r = v;
`ifdef DENSE_OUT_RELU_EN
      for (int i = 0; i < OF; i++)
         if (v[i*DW + DW - 1]) r[i*DW +: DW] = '0;
`endif
      return r;
   endfunction

   function automatic void push_vec(input logic [VW-1:0] v);
      logic [VW-1:0] s;
      s = stored(v);
      for (int k = 0; k < NB; k++) exp_q.push_back(s[k*BW +: BW]);
      $display("[TB] t=%0t vector accepted, beat0=%08h", $time, s[BW-1:0]);
   endfunction

   // One clock of stimulus; entered and left just after a rising edge
   task automatic cycle(input logic iv, input logic [VW-1:0] vec, input logic mr);
      logic exp_ready;
      ifc.in_valid = iv;
      ifc.in_data  = vec;
      ifc.m_ready  = mr;
      #2;
      exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && mr);
      chk("in_ready", ifc.in_ready, exp_ready);
      chk("m_valid",  ifc.m_valid,  exp_q.size() != 0);
      chk("m_last",   ifc.m_last,   exp_q.size() == 1);
      chk("m_data",   ifc.m_data,   exp_q.size() != 0 ? exp_q[0] : '0);
      chk("drop_cnt", ifc.drop_cnt, exp_drops);
      @(posedge clk);
      if (exp_q.size() != 0 && mr) void'(exp_q.pop_front());
      if (iv && exp_ready) begin
         push_vec(vec);
      end else if (iv) begin
         if (exp_drops < 16'hFFFF) exp_drops++;
         $display("[TB] t=%0t vector dropped, drop_cnt=%0d", $time, exp_drops);
      end
      #1;
   endtask

   task automatic do_reset();
      ifc.in_valid = 1'b0;
      ifc.m_ready  = 1'b0;
      ifc.in_data  = '0;
      rst_n = 1'b0;
      #1;
      chk("rst_m_valid",  ifc.m_valid,  0);
      chk("rst_m_last",   ifc.m_last,   0);
      chk("rst_m_data",   ifc.m_data,   0);
      chk("rst_drop_cnt", ifc.drop_cnt, 0);
      exp_q.delete();
      exp_drops = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      $display("[TB] t=%0t reset released", $time);
   endtask

   // mode 0: ready held high, 1: ready toggles starting high, 2: random ready
   task automatic drain(input int mode);
      int  n;
      logic mr;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         mr = (mode == 0) ? 1'b1 : (mode == 1) ? logic'(n % 2 == 0) : logic'($urandom_range(0, 1));
         cycle(1'b0, '0, mr);
         n++;
      end
      tests++;
      assert (exp_q.size() == 0) else begin
         fails++;
         $error("FAIL drain_timeout observed=%0d expected=0 beats left", exp_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < OF; i++) begin
         vec_a[i*DW +: DW]  = DW'(i % 256);
         vec_b[i*DW +: DW]  = DW'((1 + i*3) % 256);
         vec_aa[i*DW +: DW] = 8'hAA;
         vec_ff[i*DW +: DW] = 8'hFF;
         vec_7f[i*DW +: DW] = 8'h7F;
      end

      // 1: straight stream with ready held high
      do_reset();
      chk("t1_in_ready_idle", ifc.in_ready, 1);
      cycle(1'b1, vec_a, 1'b1);
      chk("t1_beat0", ifc.m_data, 32'h03020100);
      for (int k = 0; k < NB - 1; k++) cycle(1'b0, '0, 1'b1);
      chk("t1_beat15", ifc.m_data, 32'h3F3E3D3C);
      chk("t1_last15", ifc.m_last, 1);
      cycle(1'b0, '0, 1'b1);
      chk("t1_idle_valid", ifc.m_valid, 0);
      chk("t1_drops", ifc.drop_cnt, 0);

      // 2: toggling ready, stalls must hold beat contents
      do_reset();
      cycle(1'b1, vec_a, 1'b0);
      drain(1);

      // 3: vector arriving mid-stream is dropped
      do_reset();
      cycle(1'b1, vec_a, 1'b1);
      for (int k = 0; k < 5; k++) cycle(1'b0, '0, 1'b1);
      chk("t3_beat5", ifc.m_data, 32'h17161514);
      cycle(1'b1, vec_aa, 1'b1);
      chk("t3_beat6", ifc.m_data, 32'h1B1A1918);
      chk("t3_drops", ifc.drop_cnt, 1);
      drain(0);

      // 4: back-to-back vector on the final handshake
      do_reset();
      cycle(1'b1, vec_a, 1'b1);
      for (int k = 0; k < NB - 1; k++) cycle(1'b0, '0, 1'b1);
      cycle(1'b1, vec_b, 1'b1);
      chk("t4_no_bubble", ifc.m_valid, 1);
      chk("t4_beat0", ifc.m_data, 32'h0A070401);
      chk("t4_drops", ifc.drop_cnt, 0);
      drain(2);

      // 5: reset during beat 8, then a fresh vector
      do_reset();
      cycle(1'b1, vec_a, 1'b1);
      for (int k = 0; k < 8; k++) cycle(1'b0, '0, 1'b1);
      chk("t5_beat8", ifc.m_data, 32'h23222120);
      do_reset();
      cycle(1'b1, vec_b, 1'b1);
      chk("t5_fresh_beat0", ifc.m_data, 32'h0A070401);
      drain(0);

      // 6: sign-boundary features
      do_reset();
      cycle(1'b1, vec_ff, 1'b1);
`ifdef DENSE_OUT_RELU_EN
      chk("t6_ff", ifc.m_data, 32'h00000000);
`else
      chk("t6_ff", ifc.m_data, 32'hFFFFFFFF);
`endif
      drain(0);
      cycle(1'b1, vec_7f, 1'b1);
      chk("t6_7f", ifc.m_data, 32'h7F7F7F7F);
      drain(0);

      // Randomized traffic against the model
      do_reset();
      for (int c = 0; c < 800; c++) begin
         for (int w = 0; w < VW / 32; w++) vec_r[w*32 +: 32] = $urandom;
         cycle(logic'($urandom_range(0, 9) == 0), vec_r, logic'($urandom_range(0, 2) != 0));
      end
      drain(0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
